// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : 16x-oversampled UART receiver; LSB-first data, stop-bit check,
//            one-cycle done strobe per completed frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int NB_DATA     = 8,
    parameter int SB_TICK     = 16,
    parameter int NB_TICK_CNT = $clog2(SB_TICK),
    parameter int NB_BIT_CNT  = $clog2(NB_DATA)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [NB_TICK_CNT-1:0] START_MID = NB_TICK_CNT'(7);
    localparam logic [NB_TICK_CNT-1:0] DATA_MID  = NB_TICK_CNT'(15);
    localparam logic [NB_TICK_CNT-1:0] STOP_END  = NB_TICK_CNT'(SB_TICK - 1);
    localparam logic [NB_TICK_CNT-1:0] TICK_ONE  = NB_TICK_CNT'(1);
    localparam logic [NB_BIT_CNT-1:0]  LAST_BIT  = NB_BIT_CNT'(NB_DATA - 1);
    localparam logic [NB_BIT_CNT-1:0]  BIT_ONE   = NB_BIT_CNT'(1);

    logic                   rx_meta;
    logic                   rx_s;

    state_t                 state;
    state_t                 state_next;
    logic [NB_TICK_CNT-1:0] tick_cnt;
    logic [NB_TICK_CNT-1:0] tick_cnt_next;
    logic [NB_BIT_CNT-1:0]  bit_cnt;
    logic [NB_BIT_CNT-1:0]  bit_cnt_next;
    logic [NB_DATA-1:0]     shreg;
    logic [NB_DATA-1:0]     shreg_next;
    logic [NB_DATA-1:0]     data_next;
    logic                   frame_error_next;
    logic                   rx_done_next;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            o_data        <= '0;
            o_frame_error <= 1'b0;
            o_rx_done     <= 1'b0;
        end else begin
            state         <= state_next;
            tick_cnt      <= tick_cnt_next;
            bit_cnt       <= bit_cnt_next;
            shreg         <= shreg_next;
            o_data        <= data_next;
            o_frame_error <= frame_error_next;
            o_rx_done     <= rx_done_next;
        end
    end

    always_comb begin
        state_next       = state;
        tick_cnt_next    = tick_cnt;
        bit_cnt_next     = bit_cnt;
        shreg_next       = shreg;
        data_next        = o_data;
        frame_error_next = o_frame_error;
        rx_done_next     = 1'b0;

        case (state)
            // Start-bit detection is immediate so tick phase does not add skew.
            IDLE: begin
                if (!rx_s) begin
                    state_next    = START;
                    tick_cnt_next = '0;
                end
            end

            START: begin
                if (i_tick) begin
                    if (tick_cnt == START_MID) begin
                        tick_cnt_next = '0;
                        if (!rx_s) begin
                            state_next   = DATA;
                            bit_cnt_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt + TICK_ONE;
                    end
                end
            end

            DATA: begin
                if (i_tick) begin
                    if (tick_cnt == DATA_MID) begin
                        tick_cnt_next = '0;
                        shreg_next    = {rx_s, shreg[NB_DATA-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            state_next = STOP;
                        end else begin
                            bit_cnt_next = bit_cnt + BIT_ONE;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt + TICK_ONE;
                    end
                end
            end

            STOP: begin
                if (i_tick) begin
                    if (tick_cnt == STOP_END) begin
                        state_next       = IDLE;
                        tick_cnt_next    = '0;
                        data_next        = shreg;
                        frame_error_next = ~rx_s;
                        rx_done_next     = 1'b1;
                    end else begin
                        tick_cnt_next = tick_cnt + TICK_ONE;
                    end
                end
            end

            default: begin
                state_next    = IDLE;
                tick_cnt_next = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx; tick-level line model and
//            frame scoreboard for an 8N1 and a 7-bit/2-stop instance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick;
    logic       rx1;
    logic       rx2;
    logic [7:0] data1;
    logic [6:0] data2;
    logic       done1;
    logic       done2;
    logic       ferr1;
    logic       ferr2;

    typedef struct {
        int         at_tick;
        logic [8:0] data;
        bit         ferr;
    } exp_t;

    exp_t       e1[$];
    exp_t       e2[$];
    bit         q1[$];
    bit         q2[$];
    int         tick_idx = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         pulses1 = 0;
    int         pulses2 = 0;
    int         exp_pulses1 = 0;
    int         exp_pulses2 = 0;
    int         tdiv = 0;
    logic [8:0] last1 = '0;
    logic [8:0] last2 = '0;

    uart_rx dut1 (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_tick        (tick),
        .i_rx          (rx1),
        .o_data        (data1),
        .o_rx_done     (done1),
        .o_frame_error (ferr1)
    );

    uart_rx #(
        .NB_DATA (7),
        .SB_TICK (32)
    ) dut2 (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_tick        (tick),
        .i_rx          (rx2),
        .o_data        (data2),
        .o_rx_done     (done2),
        .o_frame_error (ferr2)
    );

    always #5 clock = ~clock;

    // One tick every 4 clocks, changed on the falling edge.
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clock);
            tdiv = (tdiv == 3) ? 0 : tdiv + 1;
            tick = (tdiv == 3);
        end
    end

    // Counts every strobe cycle, tick-aligned or not.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (done1 === 1'b1) pulses1++;
            if (done2 === 1'b1) pulses2++;
        end
    end

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Appends one frame to a line queue; element k is driven right after
    // tick (ref + k), ref being the tick after which the start bit goes low.
    task automatic add_frame(input int which, input logic [8:0] d, input bit stop_low);
        int         nb;
        int         sb;
        int         ref_t;
        bit         line[$];
        exp_t       ex;
        logic [8:0] md;
        nb = (which == 1) ? 8 : 7;
        sb = (which == 1) ? 16 : 32;
        md = d & 9'((1 << nb) - 1);
        for (int k = 0; k < 16; k++) line.push_back(1'b0);
        for (int b = 0; b < nb; b++)
            for (int k = 0; k < 16; k++) line.push_back(md[b]);
        // A low stop bit releases the line right at the strobe, so the
        // spurious restart it triggers is rejected as a glitch.
        for (int k = 0; k < sb; k++) line.push_back(stop_low ? (k >= sb - 8) : 1'b1);
        if (stop_low)
            for (int k = 0; k < 8; k++) line.push_back(1'b1);
        ex.data = md;
        ex.ferr = stop_low;
        if (which == 1) begin
            ref_t = tick_idx + 1 + q1.size();
            ex.at_tick = ref_t + 8 + 16 * nb + sb;
            foreach (line[k]) q1.push_back(line[k]);
            e1.push_back(ex);
        end else begin
            ref_t = tick_idx + 1 + q2.size();
            ex.at_tick = ref_t + 8 + 16 * nb + sb;
            foreach (line[k]) q2.push_back(line[k]);
            e2.push_back(ex);
        end
    endtask

    task automatic add_level(input int which, input bit lvl, input int n);
        for (int k = 0; k < n; k++) begin
            if (which == 1) q1.push_back(lvl);
            else            q2.push_back(lvl);
        end
    endtask

    task automatic check_port(input int which, input logic done, input logic [8:0] data,
                              input logic ferr);
        bit   have;
        exp_t ex;
        have = 1'b0;
        if (which == 1 && e1.size() > 0) begin
            ex = e1[0];
            have = (ex.at_tick == tick_idx);
            if (ex.at_tick <= tick_idx) void'(e1.pop_front());
        end
        if (which == 2 && e2.size() > 0) begin
            ex = e2[0];
            have = (ex.at_tick == tick_idx);
            if (ex.at_tick <= tick_idx) void'(e2.pop_front());
        end
        chk($sformatf("rx_done%0d@tick%0d", which, tick_idx), {8'd0, done}, {8'd0, have});
        if (have) begin
            chk($sformatf("data%0d@tick%0d", which, tick_idx), data, ex.data);
            chk($sformatf("frame_error%0d@tick%0d", which, tick_idx), {8'd0, ferr}, {8'd0, ex.ferr});
            if (which == 1) begin
                last1 = ex.data;
                exp_pulses1++;
            end else begin
                last2 = ex.data;
                exp_pulses2++;
            end
        end
    endtask

    task automatic step_tick();
        int guard;
        guard = 0;
        do begin
            @(posedge clock);
            guard++;
        end while (tick !== 1'b1 && guard < 16);
        tick_idx++;
        @(negedge clock);
        check_port(1, done1, {1'b0, data1}, ferr1);
        check_port(2, done2, {2'b0, data2}, ferr2);
        rx1 = (q1.size() > 0) ? q1.pop_front() : 1'b1;
        rx2 = (q2.size() > 0) ? q2.pop_front() : 1'b1;
    endtask

    task automatic play_all();
        int guard;
        guard = 0;
        while ((q1.size() > 0 || q2.size() > 0 || e1.size() > 0 || e2.size() > 0)
               && guard < 6000) begin
            step_tick();
            guard++;
        end
        chk("play_all_timeout", {8'd0, guard >= 6000}, 9'd0);
        repeat (4) step_tick();
        chk("pulse_count1", 9'(pulses1), 9'(exp_pulses1));
        chk("pulse_count2", 9'(pulses2), 9'(exp_pulses2));
    endtask

    initial begin
        reset = 1'b1;
        rx1   = 1'b1;
        rx2   = 1'b1;
        repeat (5) @(negedge clock);
        chk("reset_data1", {1'b0, data1}, 9'd0);
        chk("reset_done1", {8'd0, done1}, 9'd0);
        chk("reset_ferr1", {8'd0, ferr1}, 9'd0);
        chk("reset_data2", {2'b0, data2}, 9'd0);
        chk("reset_done2", {8'd0, done2}, 9'd0);
        chk("reset_ferr2", {8'd0, ferr2}, 9'd0);
        reset = 1'b0;
        repeat (4) step_tick();

        // Single 8N1 frame, strobe timing checked tick by tick.
        add_frame(1, 9'h55, 1'b0);
        play_all();

        // Back-to-back frames, no idle gap.
        add_frame(1, 9'hA5, 1'b0);
        add_frame(1, 9'h3C, 1'b0);
        play_all();

        // Four-tick low glitch must be rejected at mid start bit.
        add_level(1, 1'b0, 4);
        add_level(1, 1'b1, 24);
        play_all();
        chk("glitch_data_held", {1'b0, data1}, last1);

        // Framing error, then a clean frame clears the flag.
        add_frame(1, 9'hFF, 1'b1);
        add_frame(1, 9'h12, 1'b0);
        play_all();

        // Reset during data bit 4 of 0x81, overlapping a tick.
        add_frame(1, 9'h81, 1'b0);
        repeat (16 * 5 + 8) step_tick();
        reset = 1'b1;
        @(negedge clock);
        chk("midreset_data1", {1'b0, data1}, 9'd0);
        chk("midreset_done1", {8'd0, done1}, 9'd0);
        chk("midreset_ferr1", {8'd0, ferr1}, 9'd0);
        step_tick();
        reset = 1'b0;
        q1.delete();
        e1.delete();
        rx1   = 1'b1;
        last1 = '0;
        repeat (20) step_tick();
        chk("midreset_no_strobe", 9'(pulses1), 9'(exp_pulses1));
        add_frame(1, 9'h81, 1'b0);
        play_all();

        // 7 data bits, 2 stop bits.
        add_frame(2, 9'h4B, 1'b0);
        play_all();

        // Randomised frames on both instances concurrently.
        for (int n = 0; n < 8; n++) begin
            add_frame(1, 9'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
            add_level(1, 1'b1, $urandom_range(0, 5));
            add_frame(2, 9'($urandom_range(0, 127)), ($urandom_range(0, 3) == 0));
            add_level(2, 1'b1, $urandom_range(0, 5));
        end
        play_all();
        chk("final_data1", {1'b0, data1}, last1);
        chk("final_data2", {2'b0, data2}, last2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; sits directly downstream of the baud-rate tick generator and consumes its 16x-oversampling tick (one `i_tick` pulse per 1/16 bit period).
- Synchronises the asynchronous serial input and detects the start bit, sampling it at mid-bit.
- Shifts in NB_DATA data bits, LSB first, then checks the stop bit.
- Presents each received byte with a one-cycle done strobe to the downstream interface or FIFO.

Parameters:
- NB_DATA, 8, data bits per frame (5..9 supported).
- SB_TICK, 16, oversampling ticks spanning the stop bit(s): 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- NB_TICK_CNT, $clog2(SB_TICK), width of the tick counter; must hold max(15, SB_TICK-1).
- NB_BIT_CNT, $clog2(NB_DATA), width of the data-bit counter.

Ports:
- i_clock  input  1  system clock.
- i_reset  input  1  synchronous, active-high reset.
- i_tick  input  1  16x baud tick from the baud-rate generator; single-cycle pulse.
- i_rx  input  1  asynchronous serial line; idle high.
- o_data  output  NB_DATA  last received word; held until the next frame completes.
- o_rx_done  output  1  one-cycle pulse when a frame completes.
- o_frame_error  output  1  stop-bit value of the last frame was 0; updated together with o_data.

Behaviour:
- Clock and reset: clock is i_clock; reset is i_reset, synchronous, active-high.
- Values after reset:
  - state = IDLE; tick counter = 0; bit counter = 0; shift register = 0.
  - o_data = 0, o_rx_done = 0, o_frame_error = 0.
  - Both synchroniser flops = 1 (line idle).
- Synchroniser: i_rx passes through 2 flops; all decisions use the synchronised value rx_s, which adds 2 cycles of latency.
- Tick gating: the tick counter advances only on cycles with i_tick = 1. The FSM changes state only on tick cycles, except IDLE -> START.
- FSM states are IDLE, START, DATA, STOP.
- IDLE: when rx_s = 0 -> START and clear the tick counter. This transition does not need i_tick.
- START:
  - On a tick with tick counter = 7 (mid start bit):
    - if rx_s = 0 -> DATA, clear the tick and bit counters;
    - if rx_s = 1 -> IDLE (glitch rejected); no strobe and no output change.
  - Otherwise increment the tick counter.
- DATA:
  - On a tick with tick counter = 15 (mid data bit): shift right with rx_s entering the MSB (LSB-first reception) and clear the tick counter.
  - If bit counter = NB_DATA-1 -> STOP; else increment the bit counter.
  - Otherwise increment the tick counter.
- STOP:
  - On a tick with tick counter = SB_TICK-1: o_data <= shift register, o_frame_error <= ~rx_s, o_rx_done = 1 for exactly that one clock, then -> IDLE.
  - Otherwise increment the tick counter.
- o_rx_done:
  - Registered; high for exactly 1 clock per completed frame, including frames with a framing error.
  - Never asserted by a rejected start glitch.
- Line held low (break): the frame completes with o_frame_error = 1. The FSM then returns to IDLE, sees rx_s = 0 and starts a new frame immediately; this is the required behaviour.
- Tick counter wrap: the counter never exceeds its terminal value (7, 15 or SB_TICK-1); it is cleared on every state change.
- Reset mid-frame: takes effect on the next clock regardless of i_tick. The partial frame is discarded and no strobe is issued.
- i_tick and i_reset asserted together: reset wins.
- End-to-end latency, stop-bit sampling tick to o_rx_done: 1 clock (registered strobe).

Test Plan:
1. Tick every 4 clocks; send 0x55 with 1 stop bit (16 ticks/bit) -> exactly one o_rx_done pulse, o_data = 0x55, o_frame_error = 0, and the strobe falls on the 16th tick of the stop bit.
2. Back-to-back frames 0xA5 then 0x3C with no idle gap -> two pulses, o_data = 0xA5 then 0x3C, o_frame_error = 0 both times.
3. Low glitch on i_rx lasting 4 ticks, then line high -> FSM returns to IDLE, o_rx_done never asserts, o_data unchanged.
4. Frame 0xFF with stop bit driven 0 -> pulse asserted, o_data = 0xFF, o_frame_error = 1. The next valid frame 0x12 clears o_frame_error to 0.
5. Assert i_reset during data bit 4 of 0x81 -> all outputs 0 next clock and no strobe. The following full 0x81 frame is received correctly.
6. SB_TICK = 32, NB_DATA = 7; send 0x4B -> pulse occurs 32 ticks after the stop-bit start, o_data = 0x4B.
